// File: rtl/flappy_pkg.sv
// Shared Flappy Bird definitions: coordinate width, game mode decode and
// screen-coordinate saturation used by the world generator, game FSM and renderer.
package flappy_pkg;

    localparam int COORD_W = 32'd10;
    localparam logic [COORD_W-1:0] GAP_H     = 10'd100;
    localparam logic [COORD_W-1:0] MAX_COORD = 10'd1023;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } mode_e;

    // Anything other than a clean one-hot INIT or RUN is treated as FREEZE.
    function automatic mode_e decode_mode(input logic q_i, input logic q_en, input logic q_end);
        mode_e m;
        case ({q_i, q_en, q_end})
            3'b100:  m = INIT;
            3'b010:  m = RUN;
            default: m = FREEZE;
        endcase
        return m;
    endfunction

    function automatic logic [COORD_W-1:0] sat_coord(input logic signed [11:0] v);
        logic [COORD_W-1:0] r;
        if (v < 12'sd0) begin
            r = {COORD_W{1'b0}};
        end else if (v > $signed({2'b00, MAX_COORD})) begin
            r = MAX_COORD;
        end else begin
            r = v[COORD_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bird_world_if.sv
// Game-state inputs and world-position outputs of the bird_world generator.
interface bird_world_if;
    import flappy_pkg::*;

    logic               Tick;
    logic               Flap;
    logic               q_I;
    logic               q_EN;
    logic               q_End;
    logic [COORD_W-1:0] XBird;
    logic [COORD_W-1:0] YBird;
    logic [COORD_W-1:0] XPipe1;
    logic [COORD_W-1:0] YPipe1;
    logic [COORD_W-1:0] XPipe2;
    logic [COORD_W-1:0] YPipe2;
    logic               FrameDone;

    modport master (
        output Tick, Flap, q_I, q_EN, q_End,
        input  XBird, YBird, XPipe1, YPipe1, XPipe2, YPipe2, FrameDone
    );

    modport slave (
        input  Tick, Flap, q_I, q_EN, q_End,
        output XBird, YBird, XPipe1, YPipe1, XPipe2, YPipe2, FrameDone
    );

endinterface

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1), seeded only by Reset.
module lfsr10 (
    input  logic       Clk,
    input  logic       Reset,
    output logic [9:0] q
);

    // Shift register; feedback from bits 10 and 7 (1-based).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= 10'h2A5;
        end else begin
            q <= {q[8:0], q[9] ^ q[6]};
        end
    end

endmodule

// File: rtl/bird_world.sv
// Per-frame world-state generator: bird fall/flap physics and scrolling pipes,
// advanced on each frame tick while the game is in RUN.
module bird_world
    import flappy_pkg::*;
#(
    parameter logic [COORD_W-1:0] BIRD_X     = 10'd100,
    parameter logic [COORD_W-1:0] BIRD_Y0    = 10'd240,
    parameter logic [5:0]         GRAVITY    = 6'd1,
    parameter logic [5:0]         FLAP_V     = 6'd8,
    parameter logic [5:0]         MAX_FALL   = 6'd12,
    parameter logic [COORD_W-1:0] PIPE_SPEED = 10'd2,
    parameter logic [COORD_W-1:0] PIPE1_X0   = 10'd640,
    parameter logic [COORD_W-1:0] PIPE2_X0   = 10'd960,
    parameter logic [COORD_W-1:0] PIPE_Y0    = 10'd200,
    parameter logic [COORD_W-1:0] RESPAWN_X  = 10'd700,
    parameter logic [COORD_W-1:0] GAP_MIN    = 10'd150
) (
    input  logic         Clk,
    input  logic         Reset,
    bird_world_if.slave  bus
);

    mode_e               mode_s;
    logic [9:0]          lfsr_s;
    logic                flap_edge_s;
    logic                respawn1_s;
    logic                respawn2_s;
    logic signed [11:0]  y_ext_s;
    logic signed [11:0]  y_fall_s;
    logic signed [11:0]  y_flap_s;
    logic signed [6:0]   vy_inc_s;

    logic [COORD_W-1:0]  y_bird_r, y_bird_n;
    logic signed [5:0]   vy_r, vy_n;
    logic [COORD_W-1:0]  x_pipe1_r, x_pipe1_n;
    logic [COORD_W-1:0]  y_pipe1_r, y_pipe1_n;
    logic [COORD_W-1:0]  x_pipe2_r, x_pipe2_n;
    logic [COORD_W-1:0]  y_pipe2_r, y_pipe2_n;
    logic                flap_pend_r, flap_pend_n;
    logic                flap_q_r;
    logic                frame_done_r, frame_done_n;

    lfsr10 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .q     (lfsr_s)
    );

    assign mode_s = decode_mode(bus.q_I, bus.q_EN, bus.q_End);

    // Next world state: reload in INIT, hold in FREEZE, advance on Tick in RUN.
    always_comb begin
        y_bird_n     = y_bird_r;
        vy_n         = vy_r;
        x_pipe1_n    = x_pipe1_r;
        y_pipe1_n    = y_pipe1_r;
        x_pipe2_n    = x_pipe2_r;
        y_pipe2_n    = y_pipe2_r;
        flap_pend_n  = flap_pend_r;
        frame_done_n = 1'b0;

        flap_edge_s = bus.Flap & ~flap_q_r;
        respawn1_s  = (x_pipe1_r < PIPE_SPEED);
        respawn2_s  = (x_pipe2_r < PIPE_SPEED);
        // 12-bit signed arithmetic so the result can be clamped instead of wrapping.
        y_ext_s  = $signed({2'b00, y_bird_r});
        y_fall_s = y_ext_s + $signed({{6{vy_r[5]}}, vy_r});
        y_flap_s = y_ext_s - $signed({6'd0, FLAP_V});
        vy_inc_s = $signed({vy_r[5], vy_r}) + $signed({1'b0, GRAVITY});

        case (mode_s)
            INIT: begin
                y_bird_n    = BIRD_Y0;
                vy_n        = 6'sd0;
                x_pipe1_n   = PIPE1_X0;
                y_pipe1_n   = PIPE_Y0;
                x_pipe2_n   = PIPE2_X0;
                y_pipe2_n   = PIPE_Y0;
                flap_pend_n = 1'b0;
            end
            RUN: begin
                if (bus.Tick) begin
                    frame_done_n = 1'b1;
                    flap_pend_n  = 1'b0;
                    if (flap_pend_r || flap_edge_s) begin
                        y_bird_n = sat_coord(y_flap_s);
                        vy_n     = $signed(GRAVITY - FLAP_V);
                    end else begin
                        y_bird_n = sat_coord(y_fall_s);
                        if (vy_inc_s > $signed({1'b0, MAX_FALL})) begin
                            vy_n = $signed(MAX_FALL);
                        end else begin
                            vy_n = vy_inc_s[5:0];
                        end
                    end
                    if (respawn1_s) begin
                        x_pipe1_n = RESPAWN_X;
                        y_pipe1_n = GAP_MIN + {3'b000, lfsr_s[6:0]};
                    end else begin
                        x_pipe1_n = x_pipe1_r - PIPE_SPEED;
                    end
                    // A simultaneous respawn draws pipe 2 from a shifted LFSR window.
                    if (respawn2_s && respawn1_s) begin
                        x_pipe2_n = RESPAWN_X;
                        y_pipe2_n = GAP_MIN + {3'b000, lfsr_s[9:3]};
                    end else if (respawn2_s) begin
                        x_pipe2_n = RESPAWN_X;
                        y_pipe2_n = GAP_MIN + {3'b000, lfsr_s[6:0]};
                    end else begin
                        x_pipe2_n = x_pipe2_r - PIPE_SPEED;
                    end
                end else begin
                    flap_pend_n = flap_pend_r | flap_edge_s;
                end
            end
            FREEZE: begin
                flap_pend_n = flap_pend_r;
            end
            default: begin
                flap_pend_n = flap_pend_r;
            end
        endcase
    end

    // World-state registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            y_bird_r     <= BIRD_Y0;
            vy_r         <= 6'sd0;
            x_pipe1_r    <= PIPE1_X0;
            y_pipe1_r    <= PIPE_Y0;
            x_pipe2_r    <= PIPE2_X0;
            y_pipe2_r    <= PIPE_Y0;
            flap_pend_r  <= 1'b0;
            flap_q_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            y_bird_r     <= y_bird_n;
            vy_r         <= vy_n;
            x_pipe1_r    <= x_pipe1_n;
            y_pipe1_r    <= y_pipe1_n;
            x_pipe2_r    <= x_pipe2_n;
            y_pipe2_r    <= y_pipe2_n;
            flap_pend_r  <= flap_pend_n;
            flap_q_r     <= bus.Flap;
            frame_done_r <= frame_done_n;
        end
    end

    assign bus.XBird     = BIRD_X;
    assign bus.YBird     = y_bird_r;
    assign bus.XPipe1    = x_pipe1_r;
    assign bus.YPipe1    = y_pipe1_r;
    assign bus.XPipe2    = x_pipe2_r;
    assign bus.YPipe2    = y_pipe2_r;
    assign bus.FrameDone = frame_done_r;

endmodule

// File: tb/tb_bird_world.sv
// Directed bench for bird_world: bird physics, pipe scroll/respawn, modes and reset.
module tb_bird_world;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;
    int   ey, ev, ex1, ex2, ey1, ey2;
    logic [9:0] lfsr_m;
    logic [9:0] l1, l2;

    bird_world_if bus ();
    bird_world_if bus2 ();
    bird_world_if bus3 ();

    bird_world dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    bird_world #(.PIPE1_X0(10'd1), .PIPE2_X0(10'd2)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));
    bird_world #(.PIPE1_X0(10'd0), .PIPE2_X0(10'd1)) dut3 (.Clk(Clk), .Reset(Reset), .bus(bus3));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference LFSR: seeded by Reset only, advances every clock.
    always @(posedge Clk) begin
        if (Reset) lfsr_m <= 10'h2A5;
        else       lfsr_m <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ey = 240; ev = 0; ex1 = 640; ex2 = 960; ey1 = 200; ey2 = 200;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_xbird"}, bus.XBird, 100);
        check({tag, "_ybird"}, bus.YBird, ey);
        check({tag, "_vy"},    dut.vy_r,  ev);
        check({tag, "_xpipe1"}, bus.XPipe1, ex1);
        check({tag, "_ypipe1"}, bus.YPipe1, ey1);
        check({tag, "_xpipe2"}, bus.XPipe2, ex2);
        check({tag, "_ypipe2"}, bus.YPipe2, ey2);
    endtask

    // One RUN tick on dut: drive_flap puts an edge on Tick, expect_flap says a flap applies.
    task automatic tick_run(input string tag, input bit drive_flap, input bit expect_flap);
        bus.Flap = drive_flap;
        bus.Tick = 1'b1;
        cyc();
        bus.Tick = 1'b0;
        bus.Flap = 1'b0;
        if (expect_flap) begin
            ey = (ey - 8 < 0) ? 0 : ey - 8;
            ev = -7;
        end else begin
            ey = ey + ev;
            if (ey < 0) ey = 0;
            if (ey > 1023) ey = 1023;
            ev = (ev + 1 > 12) ? 12 : ev + 1;
        end
        ex1 = ex1 - 2;
        ex2 = ex2 - 2;
        check_all(tag);
        check({tag, "_fd_pulse"}, bus.FrameDone, 1);
        cyc();
        check({tag, "_fd_clear"}, bus.FrameDone, 0);
    endtask

    task automatic go_init();
        bus.q_EN = 1'b0; bus.q_End = 1'b0; bus.q_I = 1'b1;
        cyc();
        bus.q_I = 1'b0; bus.q_EN = 1'b1;
        model_reset();
        check_all("init");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b1;
        bus.Tick = 1'b0;  bus.Flap = 1'b0;  bus.q_I = 1'b1;  bus.q_EN = 1'b0;  bus.q_End = 1'b0;
        bus2.Tick = 1'b0; bus2.Flap = 1'b0; bus2.q_I = 1'b1; bus2.q_EN = 1'b0; bus2.q_End = 1'b0;
        bus3.Tick = 1'b0; bus3.Flap = 1'b0; bus3.q_I = 1'b1; bus3.q_EN = 1'b0; bus3.q_End = 1'b0;
        cyc();
        cyc();
        model_reset();
        check_all("reset");
        check("reset_fd", bus.FrameDone, 0);
        check("reset_lfsr", dut.u_lfsr.q, 10'h2A5);
        Reset = 1'b0;

        // INIT ignores ticks
        for (int i = 0; i < 3; i++) begin
            bus.Tick = ~bus.Tick;
            cyc();
            check("init_tick_fd", bus.FrameDone, 0);
        end
        bus.Tick = 1'b0;
        check_all("init_tick");

        // Pipe respawn: dut2 single wraps (X=1 then X=2 boundary), dut3 both together
        bus2.q_I = 1'b0; bus2.q_EN = 1'b1;
        bus3.q_I = 1'b0; bus3.q_EN = 1'b1;
        cyc();
        l1 = lfsr_m;
        bus2.Tick = 1'b1; bus3.Tick = 1'b1;
        cyc();
        bus2.Tick = 1'b0; bus3.Tick = 1'b0;
        check("wrap_x1",  bus2.XPipe1, 700);
        check("wrap_y1",  bus2.YPipe1, 150 + l1[6:0]);
        check("wrap_y1_range", (bus2.YPipe1 >= 10'd150) && (bus2.YPipe1 <= 10'd277), 1);
        check("edge_x2",  bus2.XPipe2, 0);
        check("edge_y2",  bus2.YPipe2, 200);
        check("both_x1",  bus3.XPipe1, 700);
        check("both_y1",  bus3.YPipe1, 150 + l1[6:0]);
        check("both_x2",  bus3.XPipe2, 700);
        check("both_y2",  bus3.YPipe2, 150 + l1[9:3]);
        l2 = lfsr_m;
        bus2.Tick = 1'b1;
        cyc();
        bus2.Tick = 1'b0;
        check("wrap2_x1", bus2.XPipe1, 698);
        check("wrap2_y1", bus2.YPipe1, 150 + l1[6:0]);
        check("wrap2_x2", bus2.XPipe2, 700);
        check("wrap2_y2", bus2.YPipe2, 150 + l2[6:0]);

        // Free fall, 3 ticks
        bus.q_I = 1'b0; bus.q_EN = 1'b1;
        tick_run("fall1", 1'b0, 1'b0);
        check("fall1_y_hand", bus.YBird, 240);
        tick_run("fall2", 1'b0, 1'b0);
        check("fall2_y_hand", bus.YBird, 241);
        tick_run("fall3", 1'b0, 1'b0);
        check("fall3_y_hand", bus.YBird, 243);
        check("fall3_vy_hand", dut.vy_r, 3);
        check("fall3_xp1_hand", bus.XPipe1, 634);

        // Two flap edges latched before a tick count as one flap
        go_init();
        bus.Flap = 1'b1; cyc();
        bus.Flap = 1'b0; cyc();
        bus.Flap = 1'b1; cyc();
        bus.Flap = 1'b0; cyc();
        tick_run("pend_flap", 1'b0, 1'b1);
        check("pend_flap_y_hand", bus.YBird, 232);
        check("pend_flap_vy_hand", dut.vy_r, -7);

        // Flap edge coincident with Tick
        go_init();
        tick_run("coinc_flap", 1'b1, 1'b1);
        check("coinc_flap_y_hand", bus.YBird, 232);

        // Ceiling: 243 -> 3 after 30 flaps -> 0
        go_init();
        for (int i = 0; i < 3; i++) tick_run("pre_ceil", 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) begin
            tick_run("ceil", 1'b1, 1'b1);
            if (i == 29) check("ceil_y3_hand", bus.YBird, 3);
        end
        check("ceil_y0_hand", bus.YBird, 0);

        // Long fall: velocity clamp and floor saturation
        for (int i = 0; i < 120; i++) tick_run("floor", 1'b0, 1'b0);
        check("floor_y_hand", bus.YBird, 1023);
        check("floor_vy_hand", dut.vy_r, 12);

        // FREEZE: ticks and flap edges ignored
        bus.q_EN = 1'b0; bus.q_End = 1'b1;
        bus.Flap = 1'b1; bus.Tick = 1'b1;
        cyc();
        bus.Flap = 1'b0;
        check("freeze_fd", bus.FrameDone, 0);
        cyc();
        bus.Tick = 1'b0;
        check_all("freeze");
        check("freeze_fd2", bus.FrameDone, 0);
        bus.q_End = 1'b0; bus.q_I = 1'b1; bus.q_EN = 1'b1;
        bus.Tick = 1'b1;
        cyc();
        bus.Tick = 1'b0;
        check_all("bad_mode");
        check("bad_mode_fd", bus.FrameDone, 0);
        bus.q_I = 1'b0;
        tick_run("after_freeze", 1'b0, 1'b0);

        // INIT for one cycle restores positions without reseeding the LFSR
        go_init();
        check("init_lfsr", dut.u_lfsr.q, lfsr_m);
        tick_run("after_init", 1'b0, 1'b0);

        // Reset wins over RUN and Tick
        Reset = 1'b1; bus.Tick = 1'b1;
        cyc();
        Reset = 1'b0; bus.Tick = 1'b0;
        model_reset();
        check_all("midreset");
        check("midreset_fd", bus.FrameDone, 0);
        check("midreset_lfsr", dut.u_lfsr.q, 10'h2A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
